// File: rtl/stack_unit.sv
// LIFO stack with registered pop output, sticky error flag and synchronous flush.
// Build option: define STACK_UNIT_BOUNDS_CHECK_EN to block full-push/empty-pop and flag them in err.
module stack_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_m1;
  logic             do_push;
  logic             do_pop;
  logic             bad;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign sp_m1 = sp - AW'(1);

`ifdef STACK_UNIT_BOUNDS_CHECK_EN
  assign do_push = push & ~pop & ~clear & ~full;
  assign do_pop  = pop & ~push & ~clear & ~empty;
  assign bad     = ~clear & ((push & pop) | (push & ~pop & full) | (pop & ~push & empty));
`else
  // Unchecked build: the pointer wraps freely and count only saturates.
  assign do_push = push & ~pop & ~clear;
  assign do_pop  = pop & ~push & ~clear;
  assign bad     = 1'b0;
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[sp] <= d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp      <= '0;
      count   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
    end else if (clear) begin
      sp      <= '0;
      count   <= '0;
      q_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      q_valid <= do_pop;
      if (bad) err <= 1'b1;
      if (do_push) begin
        sp <= sp + AW'(1);
        if (!full) count <= count + CW'(1);
      end else if (do_pop) begin
        q  <= mem[sp_m1];
        sp <= sp_m1;
        if (!empty) count <= count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Randomized check of stack_unit against an array/pointer model of the stack rules, plus literal scenarios.
module tb_stack_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 128;

`ifdef STACK_UNIT_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic             clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             empty;
  logic             full;
  logic [7:0]       count;
  logic             err;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .push(push), .pop(pop), .d(d),
    .q(q), .q_valid(q_valid), .empty(empty), .full(full), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // behavioural model
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_wr  [DEPTH];
  int               m_sp, m_cnt;
  logic [WIDTH-1:0] m_q;
  bit               m_qk, m_qv, m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sp = 0; m_cnt = 0; m_q = '0; m_qk = 1'b1; m_qv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int top;
    top = (m_sp + DEPTH - 1) % DEPTH;
    if (clear) begin
      m_sp = 0; m_cnt = 0; m_qv = 1'b0; m_err = 1'b0;
    end else if (push && pop) begin
      m_qv = 1'b0;
      if (BC) m_err = 1'b1;
    end else if (push) begin
      m_qv = 1'b0;
      if (BC && m_cnt == DEPTH) m_err = 1'b1;
      else begin
        m_mem[m_sp] = d; m_wr[m_sp] = 1'b1;
        m_sp = (m_sp + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
      end
    end else if (pop) begin
      if (BC && m_cnt == 0) begin
        m_err = 1'b1; m_qv = 1'b0;
      end else begin
        m_q = m_mem[top]; m_qk = m_wr[top]; m_qv = 1'b1;
        m_sp = top;
        if (m_cnt > 0) m_cnt--;
      end
    end else m_qv = 1'b0;
  endtask

  // compare process: every cycle once reset has been released
  always @(posedge clk) begin
    if (!reset_n) model_reset();
    else model_step();
    #1;
    if (chk_en) begin
      chk("q_valid", 64'(q_valid), 64'(m_qv));
      chk("count", 64'(count), 64'(m_cnt));
      chk("empty", 64'(empty), 64'(m_cnt == 0));
      chk("full", 64'(full), 64'(m_cnt == DEPTH));
      chk("err", 64'(err), 64'(m_err));
      if (m_qk) chk("q", 64'(q), 64'(m_q));
    end
  end

  task automatic cyc(input bit p, input bit po, input bit c, input logic [WIDTH-1:0] dd);
    @(negedge clk);
    push = p; pop = po; clear = c; d = dd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    model_reset();
    reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; d = '0;
    #1;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_qv", 64'(q_valid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // push three, pop three
    cyc(1, 0, 0, 32'h11); cyc(1, 0, 0, 32'h22); cyc(1, 0, 0, 32'h33);
    chk("lit_cnt3", 64'(count), 64'd3);
    cyc(0, 1, 0, 0); chk("lit_pop1", 64'(q), 64'h33); chk("lit_qv1", 64'(q_valid), 64'h1);
    cyc(0, 1, 0, 0); chk("lit_pop2", 64'(q), 64'h22);
    cyc(0, 1, 0, 0); chk("lit_pop3", 64'(q), 64'h11); chk("lit_empty", 64'(empty), 64'h1);
    cyc(0, 0, 0, 0); chk("lit_qv_drop", 64'(q_valid), 64'h0); chk("lit_qhold", 64'(q), 64'h11);

    // push then immediate pop
    cyc(1, 0, 0, 32'hA5A5A5A5);
    cyc(0, 1, 0, 0);
    chk("lit_a5", 64'(q), 64'hA5A5A5A5); chk("lit_a5_cnt", 64'(count), 64'h0);

    // fill, then one extra push
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, WIDTH'(i));
    chk("lit_full", 64'(full), 64'h1);
    cyc(1, 0, 0, 32'hFFFF);
    chk("lit_ovf_full", 64'(full), 64'h1);
    chk("lit_ovf_err", 64'(err), BC ? 64'h1 : 64'h0);
    cyc(0, 1, 0, 0);
    chk("lit_ovf_pop", 64'(q), BC ? 64'd127 : 64'hFFFF);

    // pop on empty after a flush: top slot still holds 127
    cyc(0, 0, 1, 0);
    chk("lit_clr_err", 64'(err), 64'h0);
    cyc(0, 1, 0, 0);
    chk("lit_unf_qv", 64'(q_valid), BC ? 64'h0 : 64'h1);
    chk("lit_unf_cnt", 64'(count), 64'h0);
    chk("lit_unf_err", 64'(err), BC ? 64'h1 : 64'h0);
    chk("lit_unf_q", 64'(q), 64'd127);

    // clear wins over pop
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, WIDTH'(i + 100));
    cyc(0, 1, 1, 0);
    chk("lit_cp_cnt", 64'(count), 64'h0); chk("lit_cp_empty", 64'(empty), 64'h1);
    chk("lit_cp_qv", 64'(q_valid), 64'h0); chk("lit_cp_err", 64'(err), 64'h0);

    // asynchronous reset between edges, aborting a fresh pop result
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, WIDTH'(i + 7));
    cyc(0, 1, 0, 0);
    chk("lit_pre_q", 64'(q), 64'h9);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("lit_ar_cnt", 64'(count), 64'h0); chk("lit_ar_q", 64'(q), 64'h0);
    chk("lit_ar_empty", 64'(empty), 64'h1); chk("lit_ar_qv", 64'(q_valid), 64'h0);
    #1;
    reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("lit_ar_qv2", 64'(q_valid), 64'h0);

    // randomized phases alternating push-heavy and pop-heavy
    for (int i = 0; i < 4000; i++) begin
      int r, r2;
      bit p, po;
      r  = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      if (((i / 300) % 2) == 0) begin
        p = (r2 < 70); po = (r2 >= 60 && r2 < 85);
      end else begin
        p = (r2 < 25); po = (r2 >= 20 && r2 < 90);
      end
      cyc(p, po, (r < 2), WIDTH'($urandom));
    end

    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
